cp0_commit_sequencer: RTL



---
 rtl/cp0_commit_sequencer_pkg.sv | 28 ++
 rtl/cp0_write_mask.sv | 23 ++
 rtl/cp0_commit_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cp0_commit_sequencer_pkg.sv
// Shared CP0 constants for the commit sequencer: register addresses, EXL bit,
// ExcCode width, sequencer state encoding and MTC0 write masks.
package cp0_commit_sequencer_pkg;

    localparam logic [7:0] EPC_ADDR    = 8'h70;  // {rd=14, sel=0}
    localparam logic [7:0] CAUSE_ADDR  = 8'h68;  // {rd=13, sel=0}
    localparam logic [7:0] STATUS_ADDR = 8'h60;  // {rd=12, sel=0}
    localparam logic [7:0] BADV_ADDR   = 8'h40;  // {rd=8,  sel=0}

    localparam int EXL_BIT    = 1;
    localparam int EXC_CODE_W = 5;

    localparam logic [31:0] EXL_MASK     = 32'h0000_0002;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXC_EPC,
        S_EXC_CAUSE,
        S_EXC_BADV,
        S_EXC_STATUS,
        S_ERET_STATUS,
        S_DONE_EXC,
        S_DONE_ERET
    } state_t;

endpackage

// File: rtl/cp0_write_mask.sv
// Combinational per-address mask of MTC0 data; only built when CP0_WRITE_MASK_EN
// is defined, so the default build carries no unused module.
`ifdef CP0_WRITE_MASK_EN
module cp0_write_mask
    import cp0_commit_sequencer_pkg::*;
(
    input  logic [7:0]  addr,
    input  logic [31:0] data_in,
    input  logic [31:0] status_in,
    input  logic [31:0] cause_in,
    output logic [31:0] data_out
);

    always_comb begin
        case (addr)
            STATUS_ADDR: data_out = (data_in & STATUS_WMASK) | (status_in & ~STATUS_WMASK);
            CAUSE_ADDR:  data_out = (data_in & CAUSE_WMASK)  | (cause_in  & ~CAUSE_WMASK);
            default:     data_out = data_in;
        endcase
    end

endmodule
`endif

// File: rtl/cp0_commit_sequencer.sv
// Single-port CP0 write/read sequencer: MTC0/MFC0 pass-through when idle,
// multi-cycle exception-entry and ERET write sequences. Optional CP0_WRITE_MASK_EN.
module cp0_commit_sequencer
    import cp0_commit_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_cp0_write_en,
    input  logic                  mem_cp0_read_en,
    input  logic [7:0]            mem_cp0_addr,
    input  logic [31:0]           mem_cp0_write_data,
    input  logic                  exc_valid,
    input  logic [EXC_CODE_W-1:0] exc_code,
    input  logic [31:0]           exc_epc,
    input  logic                  exc_in_delay_slot,
    input  logic                  exc_has_badvaddr,
    input  logic [31:0]           exc_badvaddr,
    input  logic                  eret_valid,
    input  logic [31:0]           status_in,
    input  logic [31:0]           cause_in,
    output logic                  rf_we,
    output logic [7:0]            rf_waddr,
    output logic [31:0]           rf_wdata,
    output logic                  rf_re,
    output logic [7:0]            rf_raddr,
    output logic                  stall_req,
    output logic                  exc_done,
    output logic                  eret_done
);

    state_t                state;
    logic [EXC_CODE_W-1:0] code_q;
    logic [31:0]           epc_q;
    logic [31:0]           badv_q;
    logic                  bd_q;
    logic                  has_badv_q;
    logic                  epc_path_q;
    logic [31:0]           mtc0_data;
    logic [31:0]           cause_data;

`ifdef CP0_WRITE_MASK_EN
    cp0_write_mask u_write_mask (
        .addr      (mem_cp0_addr),
        .data_in   (mem_cp0_write_data),
        .status_in (status_in),
        .cause_in  (cause_in),
        .data_out  (mtc0_data)
    );
`else
    assign mtc0_data = mem_cp0_write_data;
`endif

    // NOTE: capture registers are plain flops (not a memory), so they reset with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            code_q     <= '0;
            epc_q      <= '0;
            badv_q     <= '0;
            bd_q       <= 1'b0;
            has_badv_q <= 1'b0;
            epc_path_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (exc_valid) begin
                        code_q     <= exc_code;
                        epc_q      <= exc_epc;
                        badv_q     <= exc_badvaddr;
                        bd_q       <= exc_in_delay_slot;
                        has_badv_q <= exc_has_badvaddr;
                        epc_path_q <= ~status_in[EXL_BIT];
                        // Nested exception (EXL already set) keeps the original EPC and BD.
                        state      <= status_in[EXL_BIT] ? S_EXC_CAUSE : S_EXC_EPC;
                    end else if (eret_valid) begin
                        state <= S_ERET_STATUS;
                    end
                end
                S_EXC_EPC:     state <= S_EXC_CAUSE;
                S_EXC_CAUSE:   state <= has_badv_q ? S_EXC_BADV : S_EXC_STATUS;
                S_EXC_BADV:    state <= S_EXC_STATUS;
                S_EXC_STATUS:  state <= S_DONE_EXC;
                S_ERET_STATUS: state <= S_DONE_ERET;
                default:       state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        cause_data      = cause_in;
        cause_data[6:2] = code_q;
        cause_data[31]  = epc_path_q ? bd_q : cause_in[31];
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        rf_re    = 1'b0;
        rf_raddr = '0;
        case (state)
            S_IDLE: begin
                // A committing exception or ERET squashes the MEM instruction this cycle.
                if (!exc_valid && !eret_valid) begin
                    rf_we    = mem_cp0_write_en;
                    rf_waddr = mem_cp0_write_en ? mem_cp0_addr : '0;
                    rf_wdata = mem_cp0_write_en ? mtc0_data : '0;
                    rf_re    = mem_cp0_read_en;
                    rf_raddr = mem_cp0_read_en ? mem_cp0_addr : '0;
                end
            end
            S_EXC_EPC: begin
                rf_we    = 1'b1;
                rf_waddr = EPC_ADDR;
                rf_wdata = epc_q;
            end
            S_EXC_CAUSE: begin
                rf_we    = 1'b1;
                rf_waddr = CAUSE_ADDR;
                rf_wdata = cause_data;
            end
            S_EXC_BADV: begin
                rf_we    = 1'b1;
                rf_waddr = BADV_ADDR;
                rf_wdata = badv_q;
            end
            S_EXC_STATUS: begin
                rf_we    = 1'b1;
                rf_waddr = STATUS_ADDR;
                rf_wdata = status_in | EXL_MASK;
            end
            S_ERET_STATUS: begin
                rf_we    = 1'b1;
                rf_waddr = STATUS_ADDR;
                rf_wdata = status_in & ~EXL_MASK;
            end
            default: ;
        endcase
    end

    assign stall_req = (state != S_IDLE);
    assign exc_done  = (state == S_DONE_EXC);
    assign eret_done = (state == S_DONE_ERET);

endmodule
